// File: rtl/adder_pkg.sv
// Shared state encodings for multi-cycle arithmetic blocks.
// Kept separate so other serial units and benches can reuse them.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for a WIDTH-step serial loop, never below one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_adder_str.sv
// Gate-level one-bit full adder.
// Serves as the single arithmetic slice of the serial adder.
module full_adder_str (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic c_out
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, cin);
  or  g_o0 (c_out, ab_a, cx_a);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder processing one bit per clock, LSB first.
// One full-adder slice plus a carry flop; result held until next add.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_s;
  logic fa_c;

  full_adder_str u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .sum   (fa_s),
    .c_out (fa_c)
  );

  // Next-state: operand load, per-bit shift, and final result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        acc_d   = (WIDTH-1)'({fa_s, acc_q} >> 1);
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, acc_q};
          cout_d  = fa_c;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy  = (state_q == ST_ADD);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule
